// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game core: state codes,
// play-mode values and the LFSR feedback tap mask.
package genius_pkg;

  typedef enum logic [3:0] {
    ST_OFF   = 4'd0,
    ST_DIF   = 4'd1,
    ST_VEL   = 4'd4,
    ST_MODE  = 4'd6,
    ST_ADD   = 4'd8,
    ST_SHOW  = 4'd9,
    ST_GAP   = 4'd10,
    ST_INPUT = 4'd11,
    ST_WIN   = 4'd12,
    ST_LOSE  = 4'd13
  } state_t;

  localparam logic MODE_PC  = 1'b0;
  localparam logic MODE_PVP = 1'b1;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/genius_lfsr.sv
// 16-bit Fibonacci LFSR used as the colour source in PC mode; only the low
// OUT_W bits are exported.
module genius_lfsr
  import genius_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/genius_game_core.sv
// Genius game controller: menu (difficulty/speed/mode), sequence build,
// timed playback and key checking. Define INPUT_TIMEOUT_EN to time out INPUT.
module genius_game_core
  import genius_pkg::*;
#(
  parameter int          N_COLORS  = 4,
  parameter int          N_DIF     = 3,
  parameter int          N_VEL     = 2,
  parameter int          LEN_STEP  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CW        = $clog2(N_COLORS),
  localparam int         MAX_LEN   = N_DIF * LEN_STEP,
  localparam int         SW        = $clog2(MAX_LEN + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_next,
  input  logic                btn_ok,
  input  logic [N_COLORS-1:0] key,
  input  logic                timer_done,
  output logic [3:0]          state_code,
  output logic [2:0]          dif,
  output logic [1:0]          vel,
  output logic                mode_pvp,
  output logic [N_COLORS-1:0] color_out,
  output logic                timer_start,
  output logic [SW-1:0]       score,
  output logic                win,
  output logic                lose
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef INPUT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t                state;
  logic                  next_q, ok_q;
  logic [N_COLORS-1:0]   key_q;
  logic                  next_edge, ok_edge, key_single;
  logic [N_COLORS-1:0]   key_edge;
  logic [CW-1:0]         key_idx, rand_color, add_color, show0;
  logic                  add_fire, idx_last;
  logic [SW-1:0]         length, target_len;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         seq_mem [MAX_LEN];

  function automatic logic [N_COLORS-1:0] onehot(input logic [CW-1:0] c);
    return N_COLORS'(1) << c;
  endfunction

  genius_lfsr #(.SEED(LFSR_SEED), .OUT_W(CW)) u_lfsr (
    .clk   (clock),
    .rst_n (reset),
    .en    (1'b1),
    .value (rand_color)
  );

  assign next_edge  = btn_next & ~next_q;
  assign ok_edge    = btn_ok & ~ok_q;
  assign key_edge   = key & ~key_q;
  assign key_single = (key_edge != '0) && ((key_edge & (key_edge - N_COLORS'(1))) == '0);
  assign idx_last   = (SW'(idx) + SW'(1)) == length;
  assign target_len = SW'(dif) * SW'(LEN_STEP);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    key_idx = '0;
    for (int i = 0; i < N_COLORS; i++) begin
      if (key_edge[i]) key_idx = CW'(i);
    end
    add_color = (mode_pvp == MODE_PC) ? CW'(rand_color % N_COLORS) : key_idx;
    add_fire  = (state == ST_ADD) && ((mode_pvp == MODE_PC) || key_single);
    // On the first round seq[0] is being written this very cycle.
    show0     = (length == '0) ? add_color : seq_mem[0];
  end

  always_comb begin
    case (state)
      ST_DIF:  state_code = (dif > 3'd3) ? 4'd3 : {1'b0, dif};
      ST_VEL:  state_code = 4'd4 + {3'b000, vel != '0};
      ST_MODE: state_code = 4'd6 + {3'b000, mode_pvp};
      default: state_code = state;
    endcase
  end

  // NOTE: the sequence array has no reset; its contents are only read after being written.
  always_ff @(posedge clock) begin
    if (add_fire) seq_mem[length[IW-1:0]] <= add_color;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_OFF;
      next_q      <= 1'b0;
      ok_q        <= 1'b0;
      key_q       <= '0;
      dif         <= 3'd1;
      vel         <= '0;
      mode_pvp    <= MODE_PC;
      color_out   <= '0;
      timer_start <= 1'b0;
      score       <= '0;
      length      <= '0;
      idx         <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      next_q      <= btn_next;
      ok_q        <= btn_ok;
      key_q       <= key;
      timer_start <= 1'b0;
      // Only SHOW holds a colour; INPUT echoes last for a single cycle.
      if (state != ST_SHOW) color_out <= '0;
      case (state)
        ST_OFF: if (next_edge) begin
          state <= ST_DIF;
          dif   <= 3'd1;
        end
        ST_DIF: if (ok_edge) begin
          state <= ST_VEL;
          vel   <= '0;
        end else if (next_edge) begin
          dif <= (dif == 3'(N_DIF)) ? 3'd1 : dif + 3'd1;
        end
        ST_VEL: if (ok_edge) begin
          state <= ST_MODE;
        end else if (next_edge) begin
          vel <= (vel == 2'(N_VEL - 1)) ? 2'd0 : vel + 2'd1;
        end
        ST_MODE: if (ok_edge) begin
          state  <= ST_ADD;
          score  <= '0;
          length <= '0;
          idx    <= '0;
        end else if (next_edge) begin
          mode_pvp <= ~mode_pvp;
        end
        ST_ADD: if (add_fire) begin
          length      <= length + SW'(1);
          idx         <= '0;
          state       <= ST_SHOW;
          timer_start <= 1'b1;
          color_out   <= onehot(show0);
        end
        ST_SHOW: if (timer_done) begin
          state       <= ST_GAP;
          timer_start <= 1'b1;
          color_out   <= '0;
        end
        ST_GAP: if (timer_done) begin
          if (!idx_last) begin
            idx         <= idx + IW'(1);
            state       <= ST_SHOW;
            timer_start <= 1'b1;
            color_out   <= onehot(seq_mem[idx + IW'(1)]);
          end else begin
            idx         <= '0;
            state       <= ST_INPUT;
            timer_start <= TIMEOUT_EN;
          end
        end
        ST_INPUT: if (key_edge != '0) begin
          color_out <= key_edge;
          if (!key_single || key_idx != seq_mem[idx]) begin
            state <= ST_LOSE;
            lose  <= 1'b1;
          end else begin
            timer_start <= TIMEOUT_EN;
            if (!idx_last) begin
              idx <= idx + IW'(1);
            end else begin
              score <= score + SW'(1);
              if (length == target_len) begin
                state <= ST_WIN;
                win   <= 1'b1;
              end else begin
                state <= ST_ADD;
              end
            end
          end
        end else if (TIMEOUT_EN && timer_done) begin
          state <= ST_LOSE;
          lose  <= 1'b1;
        end
        ST_WIN, ST_LOSE: if (ok_edge) begin
          state <= ST_OFF;
          win   <= 1'b0;
          lose  <= 1'b0;
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_genius_game_core.sv
// Self-checking bench for genius_game_core: a phase-level game model compared
// every cycle, plus directed menu / PVP / PC / lose / win / reset scenarios.
module tb_genius_game_core;

  localparam int N_COLORS = 4;
  localparam int N_DIF    = 3;
  localparam int N_VEL    = 2;
  localparam int LEN_STEP = 2;
  localparam int SW       = $clog2(N_DIF * LEN_STEP + 1);

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                btn_next = 1'b0, btn_ok = 1'b0, timer_done = 1'b0;
  logic [N_COLORS-1:0] key = '0;
  logic [3:0]          state_code;
  logic [2:0]          dif;
  logic [1:0]          vel;
  logic                mode_pvp, timer_start, win, lose;
  logic [N_COLORS-1:0] color_out;
  logic [SW-1:0]       score;

  always #5 clock = ~clock;

  genius_game_core #(
    .N_COLORS(N_COLORS), .N_DIF(N_DIF), .N_VEL(N_VEL),
    .LEN_STEP(LEN_STEP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .btn_next(btn_next), .btn_ok(btn_ok),
    .key(key), .timer_done(timer_done), .state_code(state_code), .dif(dif),
    .vel(vel), .mode_pvp(mode_pvp), .color_out(color_out),
    .timer_start(timer_start), .score(score), .win(win), .lose(lose)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural game model ----------------
  localparam int P_OFF = 0, P_DIF = 1, P_VEL = 2, P_MODE = 3, P_ADD = 4,
                 P_SHOW = 5, P_GAP = 6, P_INPUT = 7, P_WIN = 8, P_LOSE = 9;
`ifdef INPUT_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  int       m_ph, m_dif, m_vel, m_mode, m_color, m_tstart, m_score, m_idx;
  int       m_seq[$];
  bit [15:0] m_lfsr;
  bit       m_pn, m_po;
  bit [3:0] m_pk;

  function automatic bit [15:0] lfsr_step(input bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int m_code();
    case (m_ph)
      P_OFF:   return 0;
      P_DIF:   return (m_dif > 3) ? 3 : m_dif;
      P_VEL:   return 4 + ((m_vel != 0) ? 1 : 0);
      P_MODE:  return 6 + m_mode;
      P_ADD:   return 8;
      P_SHOW:  return 9;
      P_GAP:   return 10;
      P_INPUT: return 11;
      P_WIN:   return 12;
      default: return 13;
    endcase
  endfunction

  task model_reset();
    m_ph = P_OFF; m_dif = 1; m_vel = 0; m_mode = 0; m_color = 0;
    m_tstart = 0; m_score = 0; m_idx = 0; m_seq.delete();
    m_lfsr = 16'hACE1; m_pn = 0; m_po = 0; m_pk = '0;
  endtask

  task model_step();
    bit ne, oe, td;
    bit [3:0] ke;
    int c;
    ne = btn_next & ~m_pn; oe = btn_ok & ~m_po; ke = key & ~m_pk; td = timer_done;
    m_pn = btn_next; m_po = btn_ok; m_pk = key;
    m_tstart = 0;
    if (m_ph != P_SHOW) m_color = 0;
    case (m_ph)
      P_OFF:  if (ne) begin m_ph = P_DIF; m_dif = 1; end
      P_DIF:  if (oe) begin m_ph = P_VEL; m_vel = 0; end
              else if (ne) m_dif = (m_dif == N_DIF) ? 1 : m_dif + 1;
      P_VEL:  if (oe) m_ph = P_MODE;
              else if (ne) m_vel = (m_vel + 1) % N_VEL;
      P_MODE: if (oe) begin m_ph = P_ADD; m_score = 0; m_seq.delete(); end
              else if (ne) m_mode = 1 - m_mode;
      P_ADD: begin
        c = -1;
        if (m_mode == 0) c = m_lfsr % N_COLORS;
        else if ($countones(ke) == 1) c = $clog2(ke);
        if (c >= 0) begin
          m_seq.push_back(c); m_idx = 0; m_ph = P_SHOW; m_tstart = 1;
          m_color = 1 << m_seq[0];
        end
      end
      P_SHOW: if (td) begin m_ph = P_GAP; m_tstart = 1; m_color = 0; end
      P_GAP: if (td) begin
        if (m_idx < m_seq.size() - 1) begin
          m_idx++; m_ph = P_SHOW; m_tstart = 1; m_color = 1 << m_seq[m_idx];
        end else begin
          m_idx = 0; m_ph = P_INPUT; m_tstart = TO;
        end
      end
      P_INPUT: if (ke != 0) begin
        m_color = ke;
        if ($countones(ke) != 1 || $clog2(ke) != m_seq[m_idx]) m_ph = P_LOSE;
        else begin
          m_tstart = TO;
          if (m_idx < m_seq.size() - 1) m_idx++;
          else begin
            m_score++;
            m_ph = (m_seq.size() == m_dif * LEN_STEP) ? P_WIN : P_ADD;
          end
        end
      end else if (TO && td) m_ph = P_LOSE;
      default: if (oe) m_ph = P_OFF;
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("state_code",  state_code,  m_code());
      check("dif",         dif,         m_dif);
      check("vel",         vel,         m_vel);
      check("mode_pvp",    mode_pvp,    m_mode);
      check("color_out",   color_out,   m_color);
      check("timer_start", timer_start, m_tstart);
      check("score",       score,       m_score);
      check("win",         win,         (m_ph == P_WIN)  ? 1 : 0);
      check("lose",        lose,        (m_ph == P_LOSE) ? 1 : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic press_next();
    btn_next = 1'b1; @(negedge clock); btn_next = 1'b0; @(negedge clock);
  endtask
  task automatic press_ok();
    btn_ok = 1'b1; @(negedge clock); btn_ok = 1'b0; @(negedge clock);
  endtask
  task automatic press_key(input logic [3:0] k);
    key = k; @(negedge clock); key = '0; @(negedge clock);
  endtask
  task automatic pulse_td(input int n);
    for (int i = 0; i < n; i++) begin
      timer_done = 1'b1; @(negedge clock); timer_done = 1'b0; @(negedge clock);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst state_code", state_code, 0);
    check("rst dif", dif, 1);
    check("rst vel/mode", {vel, mode_pvp}, 0);
    check("rst color/tstart", {color_out, timer_start}, 0);
    check("rst score/win/lose", {score, win, lose}, 0);
    reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge clock);

    // Menu, PC path, then two rounds to WIN (dif=1, LEN_STEP=2).
    press_next(); check("pc dif1 code", state_code, 1);
    press_ok();   check("pc vel code", state_code, 4);
    press_ok();   check("pc mode code", state_code, 6);
    btn_ok = 1'b1; @(negedge clock); btn_ok = 1'b0;
    check("pc add code", state_code, 8);
    @(negedge clock);
    check("pc show code", state_code, 9);
    check("pc show tstart", timer_start, 1);
    pulse_td(2);  check("pc input code", state_code, 11);
    press_key(4'(1 << m_seq[0]));
    check("pc round1 score", score, 1);
    check("pc round2 show", state_code, 9);
    pulse_td(4);  check("pc round2 input", state_code, 11);
    press_key(4'(1 << m_seq[0]));
    press_key(4'(1 << m_seq[1]));
    check("win code", state_code, 12);
    check("win flag", win, 1);
    check("win score", score, 2);
    press_ok();   check("win->off", state_code, 0);

    // Menu wrap and simultaneous next+ok.
    press_next();
    press_next(); check("wrap dif2", dif, 2); check("wrap code2", state_code, 2);
    press_next(); check("wrap dif3", dif, 3); check("wrap code3", state_code, 3);
    press_next(); check("wrap dif1", dif, 1); check("wrap code1", state_code, 1);
    press_ok();
    press_next(); check("vel1 code", state_code, 5); check("vel1", vel, 1);
    press_next(); check("vel wrap", vel, 0); check("vel wrap code", state_code, 4);
    press_next();
    press_ok();   check("mode code", state_code, 6);
    press_next(); check("mode pvp code", state_code, 7);
    btn_next = 1'b1; btn_ok = 1'b1; @(negedge clock);
    btn_next = 1'b0; btn_ok = 1'b0;
    check("ok wins code", state_code, 8); check("ok wins mode", mode_pvp, 1);
    repeat (3) @(negedge clock);
    check("pvp add waits", state_code, 8);
    press_key(4'b0101); check("pvp multikey ignored", state_code, 8);

    // PVP round.
    key = 4'b0100; @(negedge clock); key = '0;
    check("pvp show code", state_code, 9);
    check("pvp show color", color_out, 4'b0100);
    check("pvp show tstart", timer_start, 1);
    @(negedge clock);
    pulse_td(2);  check("pvp input code", state_code, 11);
    key = 4'b0100; @(negedge clock); key = '0;
    check("pvp echo", color_out, 4'b0100);
    check("pvp score1", score, 1);
    check("pvp back add", state_code, 8);
    @(negedge clock);
    check("pvp echo cleared", color_out, 0);

    // Round 2, then a wrong key.
    press_key(4'b0001); check("pvp r2 shows seq0", color_out, 4'b0100);
    pulse_td(4);  check("pvp r2 input", state_code, 11);
    press_key(4'b0010);
    check("wrong key code", state_code, 13); check("wrong key lose", lose, 1);
    press_ok();
    check("lose->off", state_code, 0);
    check("keep dif", dif, 1); check("keep vel", vel, 1); check("keep mode", mode_pvp, 1);

    // Input timeout behaviour.
    press_next(); press_ok(); press_ok();
    check("to mode code", state_code, 7);
    press_ok();
    press_key(4'b1000);
    pulse_td(2);  check("to input code", state_code, 11);
    pulse_td(1);
`ifdef INPUT_TIMEOUT_EN
    check("timeout lose code", state_code, 13);
    check("timeout lose flag", lose, 1);
`else
    check("no timeout stays", state_code, 11);
    press_key(4'b1001);
    check("multikey input lose", state_code, 13);
`endif
    press_ok();   check("to->off", state_code, 0);

    // Asynchronous reset in the middle of SHOW.
    press_next(); press_ok(); press_ok(); press_ok();
    press_key(4'b0010);
    check("mid show code", state_code, 9);
    check("mid show color", color_out, 4'b0010);
    #2 reset = 1'b0;
    #1;
    check("async rst color", color_out, 0);
    check("async rst code", state_code, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post rst dif", dif, 1);
    check("post rst mode", mode_pvp, 0);
    repeat (2) @(negedge clock);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/genius_game_core.md
Name: genius_game_core

Overview:
Parametrised successor of the Genius (Simon) game controller, covering both menu and gameplay.
- Menu: walks difficulty, speed and mode selection (PC or PVP).
- Game: builds a colour sequence, plays it back through an external timer handshake and checks player key presses.
- Ends in WIN or LOSE.
- Sits between the debounced button/key inputs and the board display/LED/timer blocks.

Parameters:
N_COLORS, 4, number of colour keys/LEDs (2..8); CW = $clog2(N_COLORS)
N_DIF, 3, number of difficulty levels (1..7)
N_VEL, 2, number of speed levels (1..4)
LEN_STEP, 8, sequence-length increment per difficulty; MAX_LEN = N_DIF*LEN_STEP
LFSR_SEED, 16'hACE1, reset value of the internal 16-bit LFSR (must be non-zero)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
btn_next  in  1  menu "next option" button, level; rising edge used
btn_ok  in  1  menu "confirm" button, level; rising edge used
key  in  N_COLORS  colour keys, one bit per colour, level; rising edges used
timer_done  in  1  one-cycle pulse from external timer: interval elapsed
state_code  out  4  current state (encoding below)
dif  out  3  selected difficulty, 1..N_DIF
vel  out  2  selected speed, 0..N_VEL-1; drives external timer duration
mode_pvp  out  1  0=PC, 1=PVP
color_out  out  N_COLORS  one-hot colour to light, 0 when dark
timer_start  out  1  one-cycle pulse: start external timer
score  out  $clog2(MAX_LEN+1)  rounds completed
win  out  1  level, high in WIN
lose  out  1  level, high in LOSE

Behaviour:
Reset values:
- All outputs 0, except dif=1; state OFF.
- Sequence memory contents don't-care. LFSR=LFSR_SEED.
- Reset in any state, including mid-show, returns to OFF within the asserted period.

Edge detection and LFSR:
- All buttons and keys are registered and edge-detected internally. Only 0→1 transitions act.
- LFSR is free-running every cycle: x^16+x^14+x^13+x^11.

State codes and transitions:
- OFF=0: btn_next edge → DIF1 (state code 1), dif=1.
- DIF=1..3, state_code = dif (capped at 3 when N_DIF>3):
  - btn_next → dif+1, wrapping N_DIF→1.
  - btn_ok → VEL (code 4), vel=0.
- VEL=4/5, code 4 + (vel!=0):
  - btn_next → vel+1, wrapping N_VEL-1→0.
  - btn_ok → MODE (code 6).
- MODE=6/7, code 6 + mode_pvp:
  - btn_next toggles mode_pvp.
  - btn_ok → ADD; score=0; length=0.
- If btn_next and btn_ok edges arrive in the same cycle, btn_ok wins.
- ADD=8:
  - PC: append LFSR[CW-1:0] modulo N_COLORS to seq[length]; length++; → SHOW at index 0 with a timer_start pulse. Takes 1 cycle.
  - PVP: wait for a single key edge and append that colour. Multiple simultaneous key edges are ignored.
- SHOW=9: color_out = onehot(seq[idx]). On timer_done → GAP with a timer_start pulse; color_out=0.
- GAP=10: on timer_done:
  - idx<length-1 → idx++, SHOW, timer_start pulse.
  - otherwise → INPUT, idx=0.
- INPUT=11: on a key edge, color_out echoes the key for that cycle only.
  - More than one key bit rising in one cycle → LOSE.
  - Key ≠ seq[idx] → LOSE.
  - Key matches and idx<length-1 → idx++.
  - Key matches the last entry → score++; if length == dif*LEN_STEP → WIN, else → ADD.
- WIN=12, LOSE=13: outputs hold, win/lose high. btn_ok → OFF; dif, vel and mode keep their values.
- timer_done in any state other than SHOW, GAP (or INPUT when timeout is enabled) is ignored.

Latency: one clock from input edge to state change.

Optional Feature:
INPUT_TIMEOUT_EN
- Defined: timer_start pulses on entry to INPUT and after each accepted correct key. timer_done in INPUT before any key edge → LOSE.
- Undefined: INPUT waits indefinitely and timer_done is ignored there.

Decomposition:
- Package genius_pkg: state enum with the codes above, MODE_PC/MODE_PVP constants, LFSR tap mask constant.
- Sub-module genius_lfsr: 16-bit Fibonacci LFSR with seed parameter and enable.
- Sequence memory is an inferred register array of MAX_LEN×CW bits inside genius_game_core.

Test Plan:
- Menu PC path: btn_next, btn_ok, btn_ok, btn_ok edges → state_code 1,4,6, then 8 followed by 9 on the next cycle; dif=1, vel=0, mode_pvp=0.
- Menu wrap with default parameters: from DIF, press btn_next 3× → dif 2,3,1. In VEL, btn_next → code 5, vel=1. In MODE, btn_next → code 7.
- PVP round: key=4'b0100 in ADD → SHOW with color_out=0100; after 2 timer_done pulses → INPUT; key 0100 → score=1, back to ADD.
- Wrong key: in INPUT press a colour other than seq[0] → state_code 13, lose=1. btn_ok → OFF, dif/vel/mode retained.
- WIN: LEN_STEP=2, dif=1, all correct keys through 2 rounds → state_code 12, win=1, score=2. Reset asserted mid-SHOW → OFF with color_out=0 asynchronously.
- With INPUT_TIMEOUT_EN: timer_done in INPUT with no key → LOSE. Without the macro, the same stimulus leaves the state at 11.
